// File: rtl/fifo_stream_adapter_if.sv
// Handshake bundle between an upstream FIFO read port and a valid/ready stream.
// The adapter takes the master view; the environment takes the slave view.
interface fifo_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_read_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;

    modport master (
        input  fifo_empty_i,
        input  fifo_rd_data_i,
        input  m_ready_i,
        output fifo_read_o,
        output m_valid_o,
        output m_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_rd_data_i,
        output m_ready_i,
        input  fifo_read_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Upstream FIFO read port to valid/ready stream adapter with a 2-entry skid buffer.
// Define FIFO_STREAM_ADAPTER_CNT_EN to add the xfer_count_o accepted-beat counter.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no word held, m_valid_o low
// ST_ONE   | word in output register only
// ST_TWO   | output register and skid register both full
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
`ifdef FIFO_STREAM_ADAPTER_CNT_EN
    output logic [31:0]           xfer_count_o,
`endif
    fifo_stream_adapter_if.master bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  m_valid;
    logic                  pop;
    logic                  capture;
    logic                  inflight;
    logic                  fifo_read;
    logic [2:0]            pending;

    assign m_valid = (state_q != ST_EMPTY);
    assign pop     = m_valid & bus.m_ready_i;

    // Words owned after this edge; state encoding doubles as occupancy.
    assign pending   = {1'b0, state_q} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_read = rst_n_i & ~bus.fifo_empty_i & (pending < 3'd2);

    assign bus.fifo_read_o = fifo_read;
    assign bus.m_valid_o   = m_valid;
    assign bus.m_data_o    = out_q;

    generate
        if (FWFT != 0) begin : g_fwft
            assign inflight = 1'b0;
            assign capture  = fifo_read;
        end else begin : g_registered
            logic inflight_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= fifo_read;
                end
            end

            assign inflight = inflight_q;
            assign capture  = inflight_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (capture) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (capture && !pop) begin
                    state_d = ST_TWO;
                end else if (pop && !capture) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop && !capture) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Later assignments win: a capture into an empty or draining output
    // register overrides the skid move, which only applies in ST_TWO anyway.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (pop && state_q == ST_TWO) begin
                out_q <= skid_q;
            end
            if (capture) begin
                if (state_q == ST_EMPTY || (state_q == ST_ONE && pop)) begin
                    out_q <= bus.fifo_rd_data_i;
                end else begin
                    skid_q <= bus.fifo_rd_data_i;
                end
            end
        end
    end

`ifdef FIFO_STREAM_ADAPTER_CNT_EN
    logic [31:0] xfer_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            xfer_count_q <= 32'd0;
        end else if (pop) begin
            xfer_count_q <= xfer_count_q + 32'd1;
        end
    end

    assign xfer_count_o = xfer_count_q;
`endif

    a_no_read_when_empty: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(fifo_read && bus.fifo_empty_i));

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) capture |-> (state_q != ST_TWO || pop));

    a_legal_state: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) state_q != 2'd3);

    a_hold_until_pop: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (m_valid && !bus.m_ready_i) |=> (m_valid && $stable(out_q)));

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter: one FWFT=1 and one FWFT=0 instance
// fed from identical FIFO models, checked by vector table plus scoreboards.
module tb_fifo_stream_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_adapter_if #(.DATA_WIDTH(32)) bus1 ();
    fifo_stream_adapter_if #(.DATA_WIDTH(32)) bus0 ();

`ifdef FIFO_STREAM_ADAPTER_CNT_EN
    logic [31:0] cnt1;
    logic [31:0] cnt0;
`endif

    fifo_stream_adapter #(.DATA_WIDTH(32), .FWFT(1)) u1 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
`ifdef FIFO_STREAM_ADAPTER_CNT_EN
        .xfer_count_o (cnt1),
`endif
        .bus          (bus1)
    );

    fifo_stream_adapter #(.DATA_WIDTH(32), .FWFT(0)) u0 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
`ifdef FIFO_STREAM_ADAPTER_CNT_EN
        .xfer_count_o (cnt0),
`endif
        .bus          (bus0)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] fq1[$];
    logic [31:0] fq0[$];
    logic [31:0] sq1[$];
    logic [31:0] sq0[$];
    logic [31:0] popped1[$];
    logic [31:0] popped0[$];
    logic        rdq1 = 1'b0;
    logic        rdq0 = 1'b0;
    logic        hold1 = 1'b0;
    logic        hold0 = 1'b0;
    logic [31:0] hdata1 = '0;
    logic [31:0] hdata0 = '0;

    typedef struct {
        logic        rdy;
        logic        rd1;
        logic        v1;
        logic [31:0] d1;
        logic        rd0;
        logic        v0;
        logic [31:0] d0;
    } vec_t;

    vec_t tbl[10];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // FIFO side model: applies the read sampled before the last edge.
    task automatic fifo_update();
        logic [31:0] w;
        if (rdq1 && fq1.size() > 0) begin
            w = fq1.pop_front();
            sq1.push_back(w);
        end
        bus1.fifo_empty_i   = (fq1.size() == 0);
        bus1.fifo_rd_data_i = (fq1.size() > 0) ? fq1[0] : 32'h0;
        if (rdq0 && fq0.size() > 0) begin
            w = fq0.pop_front();
            sq0.push_back(w);
            bus0.fifo_rd_data_i = w;
        end
        bus0.fifo_empty_i = (fq0.size() == 0);
    endtask

    task automatic sample();
        logic [31:0] e;
        rdq1 = bus1.fifo_read_o;
        rdq0 = bus0.fifo_read_o;
        chk("no_read_empty_u1", {31'b0, rdq1 & bus1.fifo_empty_i}, 32'h0);
        chk("no_read_empty_u0", {31'b0, rdq0 & bus0.fifo_empty_i}, 32'h0);
        if (hold1) begin
            chk("hold_valid_u1", {31'b0, bus1.m_valid_o}, 32'h1);
            chk("hold_data_u1", bus1.m_data_o, hdata1);
        end
        if (hold0) begin
            chk("hold_valid_u0", {31'b0, bus0.m_valid_o}, 32'h1);
            chk("hold_data_u0", bus0.m_data_o, hdata0);
        end
        hold1  = bus1.m_valid_o & ~bus1.m_ready_i;
        hold0  = bus0.m_valid_o & ~bus0.m_ready_i;
        hdata1 = bus1.m_data_o;
        hdata0 = bus0.m_data_o;
        if (bus1.m_valid_o && bus1.m_ready_i) begin
            e = (sq1.size() > 0) ? sq1.pop_front() : 32'hDEAD_BEEF;
            chk("order_u1", bus1.m_data_o, e);
            popped1.push_back(bus1.m_data_o);
        end
        if (bus0.m_valid_o && bus0.m_ready_i) begin
            e = (sq0.size() > 0) ? sq0.pop_front() : 32'hDEAD_BEEF;
            chk("order_u0", bus0.m_data_o, e);
            popped0.push_back(bus0.m_data_o);
        end
    endtask

    task automatic step(input logic rdy);
        @(posedge clk);
        #1;
        fifo_update();
        bus1.m_ready_i = rdy;
        bus0.m_ready_i = rdy;
        @(negedge clk);
        sample();
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq1.push_back(base + 32'(i));
            fq0.push_back(base + 32'(i));
        end
    endtask

    int t_rd1, t_rd0, t_v1, t_v0, f_pop1, f_pop0, l_pop1, l_pop0;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b1, 32'hA1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 32'hA2};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 32'hA3};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 32'hA4, 1'b0, 1'b1, 32'hA4};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'hA4, 1'b0, 1'b0, 32'hA4};

        bus1.m_ready_i = 1'b0;      bus0.m_ready_i = 1'b0;
        bus1.fifo_empty_i = 1'b1;   bus0.fifo_empty_i = 1'b1;
        bus1.fifo_rd_data_i = '0;   bus0.fifo_rd_data_i = '0;

        // Reset state, with words available so a stray read would show.
        load(32'h55, 1);
        @(posedge clk); #1; fifo_update();
        @(negedge clk);
        chk("rst_read_u1", {31'b0, bus1.fifo_read_o}, 32'h0);
        chk("rst_read_u0", {31'b0, bus0.fifo_read_o}, 32'h0);
        chk("rst_valid_u1", {31'b0, bus1.m_valid_o}, 32'h0);
        chk("rst_valid_u0", {31'b0, bus0.m_valid_o}, 32'h0);
        chk("rst_data_u1", bus1.m_data_o, 32'h0);
        chk("rst_data_u0", bus0.m_data_o, 32'h0);
        fq1.delete(); fq0.delete();
        @(posedge clk); #1; fifo_update(); rst_n = 1'b1;
        @(negedge clk); sample();

        // Stall with 4 words queued, then drain.
        load(32'hA1, 4);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rdy);
            chk($sformatf("tbl%0d_rd_u1", i), {31'b0, bus1.fifo_read_o}, {31'b0, tbl[i].rd1});
            chk($sformatf("tbl%0d_valid_u1", i), {31'b0, bus1.m_valid_o}, {31'b0, tbl[i].v1});
            chk($sformatf("tbl%0d_data_u1", i), bus1.m_data_o, tbl[i].d1);
            chk($sformatf("tbl%0d_rd_u0", i), {31'b0, bus0.fifo_read_o}, {31'b0, tbl[i].rd0});
            chk($sformatf("tbl%0d_valid_u0", i), {31'b0, bus0.m_valid_o}, {31'b0, tbl[i].v0});
            chk($sformatf("tbl%0d_data_u0", i), bus0.m_data_o, tbl[i].d0);
        end

        // Latency and full-rate streaming, ready held high.
        popped1.delete(); popped0.delete();
        t_rd1 = -1; t_rd0 = -1; t_v1 = -1; t_v0 = -1;
        f_pop1 = -1; f_pop0 = -1; l_pop1 = -1; l_pop0 = -1;
        load(32'hB1, 3);
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            if (t_rd1 < 0 && bus1.fifo_read_o) t_rd1 = k;
            if (t_rd0 < 0 && bus0.fifo_read_o) t_rd0 = k;
            if (t_v1 < 0 && bus1.m_valid_o) t_v1 = k;
            if (t_v0 < 0 && bus0.m_valid_o) t_v0 = k;
            if (bus1.m_valid_o) begin
                if (f_pop1 < 0) f_pop1 = k;
                l_pop1 = k;
            end
            if (bus0.m_valid_o) begin
                if (f_pop0 < 0) f_pop0 = k;
                l_pop0 = k;
            end
        end
        chk("latency_u1", 32'(t_v1 - t_rd1), 32'd1);
        chk("latency_u0", 32'(t_v0 - t_rd0), 32'd2);
        chk("beats_u1", 32'(popped1.size()), 32'd3);
        chk("beats_u0", 32'(popped0.size()), 32'd3);
        chk("back_to_back_u1", 32'(l_pop1 - f_pop1), 32'd2);
        chk("back_to_back_u0", 32'(l_pop0 - f_pop0), 32'd2);

        // Ready toggling every cycle over 16 words.
        popped1.delete(); popped0.delete();
        load(32'hD0, 16);
        for (int k = 0; k < 80; k++) step(k[0] == 1'b0);
        chk("toggle_beats_u1", 32'(popped1.size()), 32'd16);
        chk("toggle_beats_u0", 32'(popped0.size()), 32'd16);
        chk("toggle_last_u1", popped1[15], 32'hDF);
        chk("toggle_last_u0", popped0[15], 32'hDF);

        // Reset pulse while both instances are full.
        load(32'hC1, 6);
        for (int k = 0; k < 4; k++) step(1'b0);
        chk("full_rd_u1", {31'b0, bus1.fifo_read_o}, 32'h0);
        chk("full_rd_u0", {31'b0, bus0.fifo_read_o}, 32'h0);
        chk("full_valid_u1", {31'b0, bus1.m_valid_o}, 32'h1);
        chk("full_valid_u0", {31'b0, bus0.m_valid_o}, 32'h1);
        @(posedge clk); #1; fifo_update(); rst_n = 1'b0; #1;
        chk("midrst_valid_u1", {31'b0, bus1.m_valid_o}, 32'h0);
        chk("midrst_valid_u0", {31'b0, bus0.m_valid_o}, 32'h0);
        chk("midrst_data_u1", bus1.m_data_o, 32'h0);
        chk("midrst_data_u0", bus0.m_data_o, 32'h0);
        chk("midrst_rd_u1", {31'b0, bus1.fifo_read_o}, 32'h0);
        sq1.delete(); sq0.delete();
        hold1 = 1'b0; hold0 = 1'b0;
        @(negedge clk); sample();
        @(posedge clk); #1; fifo_update(); rst_n = 1'b1;
        @(negedge clk); sample();
        popped1.delete(); popped0.delete();
        for (int k = 0; k < 10; k++) step(1'b1);
        chk("post_rst_first_u1", (popped1.size() > 0) ? popped1[0] : 32'hFFFF_FFFF, 32'hC3);
        chk("post_rst_first_u0", (popped0.size() > 0) ? popped0[0] : 32'hFFFF_FFFF, 32'hC3);
        chk("post_rst_beats_u1", 32'(popped1.size()), 32'd4);
        chk("post_rst_beats_u0", 32'(popped0.size()), 32'd4);

`ifdef FIFO_STREAM_ADAPTER_CNT_EN
        // Counter wrap from a preloaded value.
        load(32'hE1, 3);
        step(1'b0);
        step(1'b0);
        force u1.xfer_count_q = 32'hFFFF_FFFE;
        step(1'b0);
        release u1.xfer_count_q;
        step(1'b1);
        chk("cnt_pre", cnt1, 32'hFFFF_FFFE);
        step(1'b1);
        chk("cnt_ffffffff", cnt1, 32'hFFFF_FFFF);
        step(1'b1);
        chk("cnt_wrap0", cnt1, 32'h0);
        step(1'b0);
        chk("cnt_one", cnt1, 32'h1);
        for (int k = 0; k < 4; k++) step(1'b1);
`endif

        chk("sb_drained_u1", 32'(sq1.size()), 32'd0);
        chk("sb_drained_u0", 32'(sq0.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_adapter.md
FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the data word width in bits.
REQ-002 The block SHALL have parameter FWFT, default 1: 1 = the upstream FIFO returns read data in the same cycle as the read; 0 = it returns read data one cycle after the read.
REQ-003 The block SHALL have port clk_i, input, width 1: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n_i, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port fifo_empty_i, input, width 1: the upstream FIFO empty flag.
REQ-006 The block SHALL have port fifo_rd_data_i, input, width DATA_WIDTH: the upstream FIFO read data.
REQ-007 The block SHALL have port fifo_read_o, output, width 1: read request to the upstream FIFO.
REQ-008 The block SHALL have port m_valid_o, output, width 1: downstream stream valid.
REQ-009 The block SHALL have port m_ready_i, input, width 1: downstream stream ready.
REQ-010 The block SHALL have port m_data_o, output, width DATA_WIDTH: downstream stream data.
REQ-011 The block SHALL have port xfer_count_o, output, width 32: accepted-beat count; the port is present only with FIFO_STREAM_ADAPTER_CNT_EN.

Function
REQ-012 The block SHALL hold a 2-entry buffer: an output register (drives m_data_o/m_valid_o) plus one skid register; occupancy state is one of EMPTY, ONE or TWO.
REQ-013 The block SHALL count a transfer when m_valid_o=1 and m_ready_i=1 at a rising edge ("pop").
REQ-014 The block SHALL assert fifo_read_o = !fifo_empty_i && (occupancy + inflight - pop) < 2, where pop is the combinational m_valid_o & m_ready_i; this m_ready_i-to-fifo_read_o path is intentional.
REQ-015 With FWFT=1, inflight SHALL be 0 at all times, and fifo_rd_data_i SHALL be captured at the same edge at which fifo_read_o=1.
REQ-016 With FWFT=0, inflight SHALL be a 1-bit register set by fifo_read_o, and fifo_rd_data_i SHALL be captured at the edge following the read.
REQ-017 Captured data SHALL go into the output register if it is empty or is being popped in that cycle, otherwise into the skid register.
REQ-018 On a pop in state TWO, the skid register SHALL move into the output register.
REQ-019 On a pop with a simultaneous capture, order SHALL be preserved: skid to output, and new data to skid (TWO) or to output (ONE).
REQ-020 The FSM SHALL follow: EMPTY to ONE on capture; ONE to TWO on capture without pop; ONE to EMPTY on pop without capture; TWO to ONE on pop without capture; any other combination holds the state.
REQ-021 Latency from fifo_read_o to m_valid_o SHALL be 1 cycle for FWFT=1 and 2 cycles for FWFT=0.
REQ-022 With m_ready_i held high and the FIFO non-empty, throughput SHALL be 1 beat/cycle.
REQ-023 Once m_valid_o is high, it SHALL stay high and m_data_o SHALL stay stable until a pop.
REQ-024 fifo_read_o SHALL never be asserted while fifo_empty_i=1, and the buffer SHALL never overflow.
REQ-025 Data order at m_data_o SHALL equal FIFO read order, with no duplication or loss.

Reset
REQ-026 On rst_n_i low, asynchronously: state=EMPTY, inflight=0, m_valid_o=0, m_data_o=0, skid register=0, xfer_count_o=0.
REQ-027 fifo_read_o SHALL be 0 while rst_n_i is low.
REQ-028 A reset mid-operation SHALL discard buffered and in-flight words; a word returned by the FIFO after release SHALL be captured only if requested after release.
REQ-029 Reset release SHALL be used synchronously; the first read SHALL be possible in the first cycle after release.

Configuration
REQ-030 Macro FIFO_STREAM_ADAPTER_CNT_EN defined: xfer_count_o SHALL be present and SHALL increment by 1 on each pop, wrapping 0xFFFF_FFFF to 0.
REQ-031 Macro FIFO_STREAM_ADAPTER_CNT_EN undefined: the port and the counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-032 FWFT=0, FIFO holding 0xA1,0xA2,0xA3, m_ready_i=1 -> m_data_o shows A1,A2,A3 on consecutive cycles; first m_valid_o comes 2 cycles after the first fifo_read_o.
REQ-033 FWFT=1, same data -> first m_valid_o 1 cycle after the read; 3 beats in 3 consecutive cycles.
REQ-034 m_ready_i=0 for 5 cycles with 4 words queued -> exactly 2 reads issued, m_data_o stable at word 1; releasing ready yields words 1-4 in order.
REQ-035 m_ready_i toggling every cycle over 16 words -> all 16 delivered in order, with no read issued while fifo_empty_i=1.
REQ-036 rst_n_i pulsed low mid-burst with state=TWO -> m_valid_o drops immediately, m_data_o=0; after release, the next beat is the next FIFO word.
REQ-037 With CNT_EN defined and the counter preloaded via force to 0xFFFF_FFFE, 3 pops -> xfer_count_o reads 0xFFFF_FFFF, 0, 1.
